jk_register: RTL and testbench

JK_REGISTER -- requirements
Module: jk_register

---
 rtl/jk_pkg.sv | 13 +
 rtl/jk_cell.sv | 42 ++++
 rtl/jk_register.sv | 98 +++++++++
 tb/tb_jk_register.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared mode encodings for the JK register slice.
// No logic; types and constants only.
// No flow control.
package jk_pkg;

    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_T    = 2'b01,
        MODE_D    = 2'b10,
        MODE_HOLD = 2'b11
    } mode_t;

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK/T/D next-state logic with an inversion flag.
// Purely combinational, zero latency.
// No flow control; enable and load are applied by the parent.
module jk_cell
    import jk_pkg::*;
(
    input  logic  i_q,
    input  logic  i_j,
    input  logic  i_k,
    input  mode_t i_mode,
    output logic  o_next,
    output logic  o_inv
);

    // Next state per mode; o_inv flags a JK-11 or T-1 inversion.
    always_comb begin
        o_next = i_q;
        o_inv  = 1'b0;
        case (i_mode)
            MODE_JK: begin
                case ({i_j, i_k})
                    2'b01:   o_next = 1'b0;
                    2'b10:   o_next = 1'b1;
                    2'b11: begin
                        o_next = ~i_q;
                        o_inv  = 1'b1;
                    end
                    default: o_next = i_q;
                endcase
            end
            MODE_T: begin
                if (i_j) begin
                    o_next = ~i_q;
                    o_inv  = 1'b1;
                end
            end
            MODE_D:  o_next = i_j;
            default: o_next = i_q;
        endcase
    end

endmodule

// File: rtl/jk_register.sv
// WIDTH-bit JK/T/D register with parallel load, change flag and saturating toggle counter.
// One cycle: every output is registered and reflects the previous rising edge.
// No backpressure; an update is accepted on every edge.
module jk_register
    import jk_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     j,
    input  logic [WIDTH-1:0]     k,
    input  logic                 load,
    input  logic [WIDTH-1:0]     d,
    output logic [WIDTH-1:0]     q,
    output logic [WIDTH-1:0]     q_,
    output logic                 changed,
    output logic [CNT_WIDTH-1:0] toggles,
    output logic                 toggles_sat
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // State is stored XOR'ed with RESET_VALUE so an all-zero power-up image
    // is identical to the reset state for every register in this block.
    logic [WIDTH-1:0]     r_q_enc;
    logic                 r_changed;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_sat;

    logic [WIDTH-1:0]     w_q;
    logic [WIDTH-1:0]     w_q_next;
    logic [WIDTH-1:0]     w_cell_next;
    logic [WIDTH-1:0]     w_cell_inv;
    logic                 w_toggle_evt;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    mode_t                w_mode;

    assign w_q    = r_q_enc ^ RESET_VALUE;
    assign w_mode = mode_t'(mode);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_cell u_cell (
            .i_q    (w_q[gi]),
            .i_j    (j[gi]),
            .i_k    (k[gi]),
            .i_mode (w_mode),
            .o_next (w_cell_next[gi]),
            .o_inv  (w_cell_inv[gi])
        );
    end

    // Load beats the per-bit update; only an enabled inversion is a toggle event.
    always_comb begin
        w_q_next     = w_q;
        w_toggle_evt = 1'b0;
        if (load) begin
            w_q_next = d;
        end else if (en) begin
            w_q_next     = w_cell_next;
            w_toggle_evt = |w_cell_inv;
        end
    end

    // Counter holds at all-ones instead of wrapping.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_toggle_evt && !(&r_cnt)) begin
            w_cnt_next = r_cnt + CNT_ONE;
        end
    end

    // State, change flag, counter and sticky saturation; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q_enc   <= '0;
            r_changed <= 1'b0;
            r_cnt     <= '0;
            r_sat     <= 1'b0;
        end else begin
            r_q_enc   <= w_q_next ^ RESET_VALUE;
            r_changed <= (w_q_next != w_q);
            r_cnt     <= w_cnt_next;
            r_sat     <= r_sat | (&w_cnt_next);
        end
    end

    assign q           = w_q;
    assign q_          = ~w_q;
    assign changed     = r_changed;
    assign toggles     = r_cnt;
    assign toggles_sat = r_sat;

endmodule

// File: tb/tb_jk_register.sv
// Directed self-checking bench for jk_register (WIDTH=8, CNT_WIDTH=4, RESET_VALUE=0).
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
// Each scenario task holds its own expected values.
module tb_jk_register;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic [7:0] j;
    logic [7:0] k;
    logic       load;
    logic [7:0] d;
    logic [7:0] q;
    logic [7:0] q_;
    logic       changed;
    logic [3:0] toggles;
    logic       toggles_sat;

    int total = 0;
    int bad   = 0;

    jk_register #(
        .WIDTH       (8),
        .RESET_VALUE (8'h00),
        .CNT_WIDTH   (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .mode        (mode),
        .j           (j),
        .k           (k),
        .load        (load),
        .d           (d),
        .q           (q),
        .q_          (q_),
        .changed     (changed),
        .toggles     (toggles),
        .toggles_sat (toggles_sat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b1; d = 8'hFF; en = 1'b1; mode = 2'b01; j = 8'hFF; k = 8'hFF;
        tick();
        total++; if (q !== 8'h00)       begin bad++; $display("FAIL reset_q got=%h exp=00", q); end
        total++; if (q_ !== 8'hFF)      begin bad++; $display("FAIL reset_qn got=%h exp=ff", q_); end
        total++; if (changed !== 1'b0)  begin bad++; $display("FAIL reset_changed got=%b exp=0", changed); end
        total++; if (toggles !== 4'h0)  begin bad++; $display("FAIL reset_toggles got=%h exp=0", toggles); end
        total++; if (toggles_sat !== 1'b0) begin bad++; $display("FAIL reset_sat got=%b exp=0", toggles_sat); end
        reset = 1'b0; load = 1'b0;
    endtask

    task automatic test_jk_basic();
        en = 1'b1; mode = 2'b00; j = 8'hF0; k = 8'h0F;
        tick();
        total++; if (q !== 8'hF0)       begin bad++; $display("FAIL jk_set_q got=%h exp=f0", q); end
        total++; if (q_ !== 8'h0F)      begin bad++; $display("FAIL jk_set_qn got=%h exp=0f", q_); end
        total++; if (changed !== 1'b1)  begin bad++; $display("FAIL jk_set_changed got=%b exp=1", changed); end
        total++; if (toggles !== 4'h0)  begin bad++; $display("FAIL jk_set_toggles got=%h exp=0", toggles); end
        j = 8'hFF; k = 8'hFF;
        tick();
        total++; if (q !== 8'h0F)       begin bad++; $display("FAIL jk_inv1_q got=%h exp=0f", q); end
        total++; if (toggles !== 4'h1)  begin bad++; $display("FAIL jk_inv1_toggles got=%h exp=1", toggles); end
        total++; if (changed !== 1'b1)  begin bad++; $display("FAIL jk_inv1_changed got=%b exp=1", changed); end
        tick();
        total++; if (q !== 8'hF0)       begin bad++; $display("FAIL jk_inv2_q got=%h exp=f0", q); end
        total++; if (toggles !== 4'h2)  begin bad++; $display("FAIL jk_inv2_toggles got=%h exp=2", toggles); end
    endtask

    // q=F0, j=CC, k=AA exercises invert/set/clear/hold on both nibbles -> 5C.
    task automatic test_jk_per_bit();
        en = 1'b1; mode = 2'b00; j = 8'hCC; k = 8'hAA;
        tick();
        total++; if (q !== 8'h5C)       begin bad++; $display("FAIL jk_mix_q got=%h exp=5c", q); end
        total++; if (changed !== 1'b1)  begin bad++; $display("FAIL jk_mix_changed got=%b exp=1", changed); end
        total++; if (toggles !== 4'h3)  begin bad++; $display("FAIL jk_mix_toggles got=%h exp=3", toggles); end
        j = 8'h00; k = 8'h00;
        tick();
        total++; if (q !== 8'h5C)       begin bad++; $display("FAIL jk_hold_q got=%h exp=5c", q); end
        total++; if (changed !== 1'b0)  begin bad++; $display("FAIL jk_hold_changed got=%b exp=0", changed); end
        total++; if (toggles !== 4'h3)  begin bad++; $display("FAIL jk_hold_toggles got=%h exp=3", toggles); end
    endtask

    task automatic test_hold();
        en = 1'b0; mode = 2'b00; j = 8'hFF; k = 8'hFF;
        tick();
        total++; if (q !== 8'h5C)       begin bad++; $display("FAIL en0_q got=%h exp=5c", q); end
        total++; if (changed !== 1'b0)  begin bad++; $display("FAIL en0_changed got=%b exp=0", changed); end
        total++; if (toggles !== 4'h3)  begin bad++; $display("FAIL en0_toggles got=%h exp=3", toggles); end
        en = 1'b1; mode = 2'b11;
        tick();
        total++; if (q !== 8'h5C)       begin bad++; $display("FAIL mode11_q got=%h exp=5c", q); end
        total++; if (toggles !== 4'h3)  begin bad++; $display("FAIL mode11_toggles got=%h exp=3", toggles); end
    endtask

    task automatic test_saturation();
        logic [3:0] exp_cnt;
        logic       exp_sat;
        logic [7:0] exp_q;
        reset = 1'b1;
        tick();
        reset = 1'b0; en = 1'b1; mode = 2'b01; j = 8'h01; k = 8'hFF;
        for (int n = 1; n <= 20; n++) begin
            tick();
            exp_cnt = (n < 15) ? 4'(n) : 4'hF;
            exp_sat = (n >= 15);
            exp_q   = (n % 2 == 1) ? 8'h01 : 8'h00;
            total++; if (q !== exp_q)         begin bad++; $display("FAIL sat_q edge=%0d got=%h exp=%h", n, q, exp_q); end
            total++; if (toggles !== exp_cnt) begin bad++; $display("FAIL sat_cnt edge=%0d got=%h exp=%h", n, toggles, exp_cnt); end
            total++; if (toggles_sat !== exp_sat) begin bad++; $display("FAIL sat_flag edge=%0d got=%b exp=%b", n, toggles_sat, exp_sat); end
            total++; if (changed !== 1'b1)    begin bad++; $display("FAIL sat_changed edge=%0d got=%b exp=1", n, changed); end
        end
    endtask

    task automatic test_load();
        reset = 1'b1;
        tick();
        total++; if (toggles_sat !== 1'b0) begin bad++; $display("FAIL sat_cleared got=%b exp=0", toggles_sat); end
        reset = 1'b0; en = 1'b1; mode = 2'b01; j = 8'h01;
        tick();
        total++; if (toggles !== 4'h1)  begin bad++; $display("FAIL pre_load_toggles got=%h exp=1", toggles); end
        load = 1'b1; d = 8'hA5; mode = 2'b00; j = 8'hFF; k = 8'hFF;
        tick();
        total++; if (q !== 8'hA5)       begin bad++; $display("FAIL load_q got=%h exp=a5", q); end
        total++; if (changed !== 1'b1)  begin bad++; $display("FAIL load_changed got=%b exp=1", changed); end
        total++; if (toggles !== 4'h1)  begin bad++; $display("FAIL load_toggles got=%h exp=1", toggles); end
        load = 1'b0; en = 1'b0;
        tick();
        total++; if (q !== 8'hA5)       begin bad++; $display("FAIL post_load_hold_q got=%h exp=a5", q); end
        total++; if (changed !== 1'b0)  begin bad++; $display("FAIL post_load_changed got=%b exp=0", changed); end
        load = 1'b1; d = 8'h5A; mode = 2'b11;
        tick();
        total++; if (q !== 8'h5A)       begin bad++; $display("FAIL load_en0_q got=%h exp=5a", q); end
        total++; if (changed !== 1'b1)  begin bad++; $display("FAIL load_en0_changed got=%b exp=1", changed); end
        tick();
        total++; if (changed !== 1'b0)  begin bad++; $display("FAIL load_same_changed got=%b exp=0", changed); end
        total++; if (toggles !== 4'h1)  begin bad++; $display("FAIL load_same_toggles got=%h exp=1", toggles); end
        load = 1'b0;
    endtask

    task automatic test_dmode();
        en = 1'b1; mode = 2'b10; j = 8'h3C; k = 8'hFF;
        tick();
        total++; if (q !== 8'h3C)       begin bad++; $display("FAIL d1_q got=%h exp=3c", q); end
        total++; if (changed !== 1'b1)  begin bad++; $display("FAIL d1_changed got=%b exp=1", changed); end
        total++; if (toggles !== 4'h1)  begin bad++; $display("FAIL d1_toggles got=%h exp=1", toggles); end
        tick();
        total++; if (q !== 8'h3C)       begin bad++; $display("FAIL d2_q got=%h exp=3c", q); end
        total++; if (changed !== 1'b0)  begin bad++; $display("FAIL d2_changed got=%b exp=0", changed); end
        j = 8'hC3;
        tick();
        total++; if (q !== 8'hC3)       begin bad++; $display("FAIL d_allinv_q got=%h exp=c3", q); end
        total++; if (toggles !== 4'h1)  begin bad++; $display("FAIL d_allinv_toggles got=%h exp=1", toggles); end
    endtask

    task automatic test_reset_override();
        en = 1'b1; mode = 2'b01; j = 8'hFF;
        tick();
        tick();
        total++; if (q !== 8'hC3)       begin bad++; $display("FAIL t_pre_rst_q got=%h exp=c3", q); end
        total++; if (toggles !== 4'h3)  begin bad++; $display("FAIL t_pre_rst_toggles got=%h exp=3", toggles); end
        reset = 1'b1; load = 1'b1; d = 8'h77;
        tick();
        total++; if (q !== 8'h00)       begin bad++; $display("FAIL rst_ovr_q got=%h exp=00", q); end
        total++; if (q_ !== 8'hFF)      begin bad++; $display("FAIL rst_ovr_qn got=%h exp=ff", q_); end
        total++; if (changed !== 1'b0)  begin bad++; $display("FAIL rst_ovr_changed got=%b exp=0", changed); end
        total++; if (toggles !== 4'h0)  begin bad++; $display("FAIL rst_ovr_toggles got=%h exp=0", toggles); end
        total++; if (toggles_sat !== 1'b0) begin bad++; $display("FAIL rst_ovr_sat got=%b exp=0", toggles_sat); end
        reset = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mode = 2'b11; j = 8'h00; k = 8'h00; load = 1'b0; d = 8'h00;
        test_reset();
        test_jk_basic();
        test_jk_per_bit();
        test_hold();
        test_saturation();
        test_load();
        test_dmode();
        test_reset_override();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
